// File: rtl/jk_ctrl_pkg.sv
// Shared types for the jk_ff bank command controller: op codes, FSM states and
// the op-to-{j,k} mapping.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        OpSet   = 2'b00,
        OpClr   = 2'b01,
        OpTog   = 2'b10,
        OpPulse = 2'b11
    } jk_op_t;

    typedef enum logic {
        StRun    = 1'b0,
        StPulse2 = 1'b1
    } jk_ctrl_state_t;

    // PULSE drives a set on the grant edge; its clear comes from the FSM later.
    function automatic logic [1:0] op_to_jk(input jk_op_t op);
        logic [1:0] jk;
        unique case (op)
            OpSet:   jk = 2'b10;
            OpClr:   jk = 2'b01;
            OpTog:   jk = 2'b11;
            OpPulse: jk = 2'b10;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Plain JK flip-flop without reset; the controller supplies reset via j/k.
module jk_ff (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    // JK update: 10 set, 01 clear, 11 toggle, 00 hold.
    always_ff @(posedge clk) begin
        case ({j, k})
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
            2'b11:   q <= ~q;
            default: q <= q;
        endcase
    end

    assign qb = ~q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned    cand;
    logic [IDW-1:0] cand_idx;
    logic           found;

    // Upward scan from rr_ptr; pointer moves just past the winner.
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDW'(cand);
            if (en && !found && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                gnt_id        = cand_idx;
                found         = 1'b1;
            end
        end
        if (found) begin
            rr_ptr_d = (int'(gnt_id) == int'(N) - 1) ? '0 : gnt_id + IDW'(1);
        end
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command controller for a jk_ff bank: round-robin grants one set/clear/toggle/
// pulse per cycle, drives every bit's J/K, and provides the bank reset.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IW    = $clog2(NBITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [IW*NREQ-1:0]       req_idx,
    output logic [NREQ-1:0]          req_ready,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [NBITS-1:0]         q
);

    localparam int GW = $clog2(NREQ);

    jk_ctrl_state_t state_q, state_d;
    logic [IW-1:0]  pulse_idx_q, pulse_idx_d;
    logic [NBITS-1:0] j_bank, k_bank;
    logic [NREQ-1:0]  gnt;
    logic [GW-1:0]    gnt_id;
    logic             arb_en;
    jk_op_t           sel_op;
    logic [IW-1:0]    sel_idx;

    assign arb_en = !rst && (state_q == StRun);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign grant_id  = gnt_id;
    assign busy      = (state_q == StPulse2) && !rst;
    assign sel_op    = jk_op_t'(req_op[2*int'(gnt_id) +: 2]);
    assign sel_idx   = req_idx[IW*int'(gnt_id) +: IW];

    // Next state and bank J/K; reset clears every bit and drops a pending pulse clear.
    always_comb begin
        j_bank      = '0;
        k_bank      = '0;
        state_d     = state_q;
        pulse_idx_d = pulse_idx_q;
        if (rst) begin
            k_bank  = '1;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (|gnt) begin
                        // Out-of-range targets are consumed with the bank left holding.
                        if (int'(sel_idx) < NBITS) begin
                            {j_bank[sel_idx], k_bank[sel_idx]} = op_to_jk(sel_op);
                        end
                        if (sel_op == OpPulse) begin
                            state_d     = StPulse2;
                            pulse_idx_d = sel_idx;
                        end
                    end
                end
                StPulse2: begin
                    if (int'(pulse_idx_q) < NBITS) begin
                        k_bank[pulse_idx_q] = 1'b1;
                    end
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    // FSM state and latched pulse target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            pulse_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            pulse_idx_q <= pulse_idx_d;
        end
    end

    for (genvar b = 0; b < NBITS; b++) begin : g_bank
        jk_ff u_ff (
            .clk (clk),
            .j   (j_bank[b]),
            .k   (k_bank[b]),
            .q   (q[b]),
            .qb  ()
        );
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: per-cycle reference model for two instances
// (8-bit and 6-bit bank) plus literal checks of grant order and q per test.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  rv   [2];
    logic [7:0]  rop  [2];
    logic [11:0] ridx [2];
    logic [3:0]  rdy  [2];
    logic        bsy  [2];
    logic [1:0]  gid  [2];
    logic [7:0]  qa;
    logic [5:0]  qb6;

    jk_bank_ctrl #(.NREQ(4), .NBITS(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv[0]),
        .req_op    (rop[0]),
        .req_idx   (ridx[0]),
        .req_ready (rdy[0]),
        .busy      (bsy[0]),
        .grant_id  (gid[0]),
        .q         (qa)
    );

    jk_bank_ctrl #(.NREQ(4), .NBITS(6)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv[1]),
        .req_op    (rop[1]),
        .req_idx   (ridx[1]),
        .req_ready (rdy[1]),
        .busy      (bsy[1]),
        .grant_id  (gid[1]),
        .q         (qb6)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] idx;
    } cmd_t;

    typedef struct {
        int         d;
        int         g;
        logic [7:0] q;
        logic       b;
    } log_t;

    int   vec = 0;
    int   mis = 0;
    cmd_t cq [8][$];
    log_t lg [$];
    logic [3:0] xfer [2];
    logic logpend [2];
    int   lgid [2];

    // Reference model state
    logic [7:0] mq [2];
    int   mptr [2];
    int   mpend [2];
    bit   mvalid [2];

    task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s dut%0d: got %h, want %h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // Requester agents: present queued commands, hold until transferred.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                cmd_t c;
                if (rv[d][i] && xfer[d][i]) rv[d][i] = 1'b0;
                if (!rv[d][i] && cq[d*4+i].size() > 0) begin
                    c = cq[d*4+i].pop_front();
                    rv[d][i]         = 1'b1;
                    rop[d][2*i +: 2]  = c.op;
                    ridx[d][3*i +: 3] = c.idx;
                end
            end
        end
    end

    // Compare process: check outputs against the model, then advance the model.
    always @(negedge clk) begin : compare
        logic [7:0] qv;
        logic [3:0] er;
        logic       eb;
        logic [1:0] opv;
        int nb, g, iv;
        for (int d = 0; d < 2; d++) begin
            qv = (d == 0) ? qa : {2'b00, qb6};
            nb = (d == 0) ? 8 : 6;
            if (logpend[d]) begin
                lg.push_back('{d, lgid[d], qv, bsy[d]});
                logpend[d] = 1'b0;
            end
            xfer[d] = rv[d] & rdy[d];
            if (|xfer[d]) begin
                logpend[d] = 1'b1;
                lgid[d]    = int'(gid[d]);
            end
            g  = -1;
            er = 4'b0;
            eb = 1'b0;
            if (!rst && mpend[d] < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && rv[d][(mptr[d] + k) % 4]) g = (mptr[d] + k) % 4;
                end
            end
            if (!rst && mpend[d] >= 0) eb = 1'b1;
            else if (g >= 0) er = 4'(1 << g);
            if (mvalid[d]) begin
                chk("ready", d, 8'(rdy[d]), 8'(er));
                chk("busy", d, 8'(bsy[d]), 8'(eb));
                if (rst || g >= 0) chk("grant_id", d, 8'(gid[d]), (g < 0) ? 8'd0 : 8'(g));
                chk("q", d, qv, mq[d]);
            end
            if (rst) begin
                mq[d] = 8'h00; mptr[d] = 0; mpend[d] = -1; mvalid[d] = 1'b1;
            end else if (mvalid[d]) begin
                if (mpend[d] >= 0) begin
                    if (mpend[d] < nb) mq[d][mpend[d]] = 1'b0;
                    mpend[d] = -1;
                end else if (g >= 0) begin
                    mptr[d] = (g + 1) % 4;
                    opv = rop[d][2*g +: 2];
                    iv  = int'(ridx[d][3*g +: 3]);
                    if (iv < nb) begin
                        case (opv)
                            2'b00:   mq[d][iv] = 1'b1;
                            2'b01:   mq[d][iv] = 1'b0;
                            2'b10:   mq[d][iv] = ~mq[d][iv];
                            default: mq[d][iv] = 1'b1;
                        endcase
                    end
                    if (opv == 2'b11) mpend[d] = iv;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < 200) begin
            @(negedge clk);
            n++;
            idle = (rv[d] == 4'b0);
            for (int i = 0; i < 4; i++) if (cq[d*4+i].size() != 0) idle = 1'b0;
        end
        vec++;
        if (!idle) begin
            mis++;
            $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, want idle", d, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_log(input string nm, input int d, input int n,
                           input int ge [4], input logic [7:0] qe [4]);
        chk({nm, "_count"}, d, 8'(lg.size()), 8'(n));
        for (int i = 0; i < n; i++) begin
            if (i < lg.size()) begin
                chk({nm, "_gid"}, d, 8'(lg[i].g), 8'(ge[i]));
                chk({nm, "_q"}, d, lg[i].q, qe[i]);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ge [4];
        logic [7:0] qe [4];
        int n;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rop[d] = '0; ridx[d] = '0;
            xfer[d] = '0; logpend[d] = 1'b0; lgid[d] = 0;
            mq[d] = '0; mptr[d] = 0; mpend[d] = -1; mvalid[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Random prior state, then a one-cycle reset must clear it.
        for (int i = 0; i < 3; i++) cq[0].push_back('{2'b00, 3'($urandom_range(0, 7))});
        wait_idle(0);
        do_reset();
        @(negedge clk);
        chk("reset_q", 0, qa, 8'h00);
        chk("reset_ready", 0, 8'(rdy[0]), 8'h00);
        chk("reset_busy", 0, 8'(bsy[0]), 8'h00);

        // Single requester: SET, TOG, TOG, CLR on bit 3.
        lg.delete();
        cq[0].push_back('{2'b00, 3'd3});
        cq[0].push_back('{2'b10, 3'd3});
        cq[0].push_back('{2'b10, 3'd3});
        cq[0].push_back('{2'b01, 3'd3});
        wait_idle(0);
        ge = '{0, 0, 0, 0}; qe = '{8'h08, 8'h00, 8'h08, 8'h00};
        chk_log("single", 0, 4, ge, qe);

        // All four requesters at once from rr_ptr=0.
        do_reset();
        lg.delete();
        for (int i = 0; i < 4; i++) cq[i].push_back('{2'b00, 3'(i)});
        wait_idle(0);
        ge = '{0, 1, 2, 3}; qe = '{8'h01, 8'h03, 8'h07, 8'h0F};
        chk_log("rr0", 0, 4, ge, qe);
        cq[0].push_back('{2'b01, 3'd0});
        wait_idle(0);
        chk("ptr_setup_q", 0, qa, 8'h0E);
        lg.delete();
        for (int i = 0; i < 4; i++) cq[i].push_back('{2'b00, 3'(4 + i)});
        wait_idle(0);
        ge = '{1, 2, 3, 0}; qe = '{8'h2E, 8'h6E, 8'hEE, 8'hFE};
        chk_log("rr1", 0, 4, ge, qe);

        // PULSE from requester 2 with requester 3 pending.
        do_reset();
        lg.delete();
        cq[2].push_back('{2'b11, 3'd7});
        cq[3].push_back('{2'b00, 3'd0});
        wait_idle(0);
        ge = '{2, 3, 0, 0}; qe = '{8'h80, 8'h01, 8'h00, 8'h00};
        chk_log("pulse", 0, 2, ge, qe);
        if (lg.size() > 0) chk("pulse_busy", 0, 8'(lg[0].b), 8'h01);
        chk("pulse_final_q", 0, qa, 8'h01);

        // Reset landing in the PULSE2 cycle.
        do_reset();
        cq[1].push_back('{2'b11, 3'd2});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rv[0][1] && rdy[0][1]) && n < 50);
        chk("pulse_grant_seen", 0, 8'(rdy[0]), 8'h02);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pulse2_q", 0, qa, 8'h00);
        chk("rst_pulse2_busy", 0, 8'(bsy[0]), 8'h00);
        lg.delete();
        cq[3].push_back('{2'b00, 3'd1});
        cq[0].push_back('{2'b00, 3'd4});
        wait_idle(0);
        ge = '{0, 3, 0, 0}; qe = '{8'h10, 8'h12, 8'h00, 8'h00};
        chk_log("after_rst", 0, 2, ge, qe);

        // Out-of-range index on the 6-bit bank.
        lg.delete();
        cq[4].push_back('{2'b00, 3'd7});
        cq[5].push_back('{2'b00, 3'd2});
        wait_idle(1);
        ge = '{0, 1, 0, 0}; qe = '{8'h00, 8'h04, 8'h00, 8'h00};
        chk_log("oor", 1, 2, ge, qe);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
